cim_conv_array_acc: RTL and testbench
=====================================

Name: cim_conv_array_acc

Overview:
- Parametrised K x K array of existing `Macro` instances with a horizontal activation shift pipeline and a K*K-input signed adder tree.
- Adds an output-width accumulation line buffer, so a convolution row can be summed over several input-channel passes, with weights reloaded between passes.
- Adds a valid/ready handshake on input and output. Sits between the activation line feeder and the output quantiser.

Parameters:
- K, 3, kernel size; array is K x K macros; K >= 2.
- MAX_W, 32, maximum activation row width in beats.
- MAX_PASS, 16, maximum accumulation passes.
- MAC_W, 14, signed PSUM width per Macro column (fixed by Macro).
- TREE_W, MAC_W+$clog2(K*K), adder-tree output width.
- ACC_W, TREE_W+$clog2(MAX_PASS), accumulator/output width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CIM_en  in  1  enables compute in all macros
- STDW  in  1  standard weight write
- STDR  in  1  standard weight read
- STD_A  in  6  macro row address for STDW/STDR
- weight_in  in  K*K*32  per-macro 4b x 8 weights; macro (c,r) at slice index r*K+c
- weight_out  out  K*K*32  per-macro readback
- act_in  in  K*256  one 4b x 64 vector per kernel row
- in_valid  in  1  act_in beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- cfg_width  in  $clog2(MAX_W+1)  row width W; sampled at start
- cfg_passes  in  $clog2(MAX_PASS+1)  pass count P; sampled at start
- start  in  1  pulse: begin new accumulation job
- out_data  out  8*ACC_W  8 signed accumulated sums
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- busy  out  1  job in progress
- pass_done  out  1  one-cycle pulse at the end of each non-final pass

Behaviour:
- Reset: all shift columns, counters and accumulator buffer are 0; out_valid=0, out_data=0, busy=0, pass_done=0, state=IDLE.
- FSM states: IDLE, WAIT_PASS, STREAM, DRAIN.
  - IDLE + start with 2<=W<=MAX_W, W>=K, 1<=P<=MAX_PASS -> STREAM; pass=0, x=0. An illegal cfg ignores start.
  - STREAM: each accepted beat shifts column c<-c-1 (column 0 = act_in, combinational into macros col 0) and increments x.
  - Beats 0..K-2 of every pass are fill only. Beat x>=K-1 produces tree result T for output index o=x-(K-1).
  - Buffer update: acc[o] <= (pass==0 ? 0 : acc[o]) + sign-extended T.
  - On the last pass, out_data <= acc[o]+T instead (buffer write optional) and out_valid=1.
  - After beat W-1: if non-final pass -> pass_done pulse, pass++, WAIT_PASS. If final pass -> DRAIN.
  - WAIT_PASS: shift columns cleared to 0, x=0. The next start -> STREAM (cfg not resampled).
  - DRAIN: hold until out_valid is consumed -> IDLE, busy=0.
- Handshake:
  - in_ready = (state==STREAM) && !STDW && !STDR && !(out_valid && !out_ready).
  - out_valid stays high until out_ready. There is no bypass, so each accepted beat costs a 1-cycle latency to out_valid.
- Weight access: STDW/STDR pass to macros in any state, but the team only issues them in IDLE/WAIT_PASS. While they are asserted no beat is accepted.
- Macros are fed CIM_en && state==STREAM.
- Arithmetic: all sums are signed two's complement with sign extension before add. Overflow cannot occur within the parameter bounds.
- Boundaries:
  - start during STREAM/DRAIN is ignored.
  - in_valid while in_ready=0 is held upstream.
  - Simultaneous out_ready and a new beat: output register reloads in the same cycle.
  - rst_n low mid-job: immediate abort to reset values.

Optional Feature:
- CIM_ACC_RELU_EN defined: final out_data lanes that are negative are clamped to 0; the buffer keeps raw signed values.
- Undefined: out_data is the raw signed sum.

Decomposition:
- Shared package cim_pkg holds:
  - MACRO_ROWS=64, MACRO_COLS=8, ACT_W=4, WGT_W=4, MAC_W=14.
  - FSM state enum.
  - Width-function helpers.
- Sub-module cim_acc_linebuf: MAX_W x 8 x ACC_W register buffer with clear-on-first-pass add and read port.
- Existing Macro is reused unchanged.
- The adder tree is generated inline for K*K inputs.

Test Plan:
- K=3, all weights 1, all acts 1, W=5, P=1 -> 3 outputs, each lane 576; out_valid exactly 3 beats; busy falls after the last is accepted.
- Same setup, P=2, start again after pass_done -> no outputs in pass 0; 3 outputs of 1152 in pass 1.
- Weights -1 (4b 0xF), acts 1, P=1 -> lanes -576; with CIM_ACC_RELU_EN -> 0.
- out_ready held 0 for 4 cycles mid-stream -> in_ready=0, out_data stable; no beat lost or duplicated (sequence check).
- STDW row 5 in WAIT_PASS, then STDR row 5 -> weight_out equals written value; accumulation continues correctly.
- rst_n pulsed low during pass 1, beat 3 -> all outputs 0 and IDLE; a fresh job then gives the first-scenario results.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared constants, FSM state encoding and width helpers for the CIM convolution array.
package cim_pkg;

  localparam int MACRO_ROWS = 64;
  localparam int MACRO_COLS = 8;
  localparam int ACT_W      = 4;
  localparam int WGT_W      = 4;
  localparam int MAC_W      = 14;
  localparam int ACT_VEC_W  = MACRO_ROWS * ACT_W;
  localparam int WGT_ROW_W  = MACRO_COLS * WGT_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PASS = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  function automatic int tree_w(input int mac_w, input int k);
    return mac_w + $clog2(k * k);
  endfunction

  function automatic int acc_w(input int t_w, input int max_pass);
    return t_w + $clog2(max_pass);
  endfunction

endpackage

// File: rtl/Macro.sv
// CIM macro: 64 rows x 8 columns of signed 4b weights; each column's signed dot product with
// the 4b activation vector appears combinationally on psum while CIM_en is high.
module Macro
  import cim_pkg::*;
(
  input  logic                          clk,
  input  logic                          CIM_en,
  input  logic                          STDW,
  input  logic                          STDR,
  input  logic [5:0]                    STD_A,
  input  logic [WGT_ROW_W-1:0]          weight_in,
  output logic [WGT_ROW_W-1:0]          weight_out,
  input  logic [ACT_VEC_W-1:0]          act_in,
  output logic [MACRO_COLS*MAC_W-1:0]   psum
);

  // Weight array behaves like SRAM: not cleared by reset.
  logic [WGT_ROW_W-1:0] wmem [MACRO_ROWS];
  logic signed [MAC_W-1:0] col_sum;

  always_ff @(posedge clk) begin
    if (STDW) wmem[STD_A] <= weight_in;
  end

  assign weight_out = STDR ? wmem[STD_A] : '0;

  always_comb begin
    psum    = '0;
    col_sum = '0;
    if (CIM_en) begin
      for (int c = 0; c < MACRO_COLS; c++) begin
        col_sum = '0;
        for (int r = 0; r < MACRO_ROWS; r++) begin
          col_sum = col_sum + MAC_W'($signed(act_in[r*ACT_W +: ACT_W]))
                            * MAC_W'($signed(wmem[r][c*WGT_W +: WGT_W]));
        end
        psum[c*MAC_W +: MAC_W] = col_sum;
      end
    end
  end

endmodule

// File: rtl/cim_acc_linebuf.sv
// Per-output-position accumulator: sum = (first ? 0 : buf[addr]) + addend, written back on wr_en.
module cim_acc_linebuf #(
  parameter int DEPTH = 32,
  parameter int LANES = 8,
  parameter int ACC_W = 22,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   first,
  input  logic [AW-1:0]          addr,
  input  logic [LANES*ACC_W-1:0] addend,
  output logic [LANES*ACC_W-1:0] sum
);

  logic [LANES*ACC_W-1:0] mem [DEPTH];

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum[l*ACC_W +: ACC_W] = (first ? '0 : mem[addr][l*ACC_W +: ACC_W])
                            + addend[l*ACC_W +: ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[addr] <= sum;
    end
  end

endmodule

// File: rtl/cim_conv_array_acc.sv
// K x K CIM macro array with activation shift columns, adder tree and multi-pass row accumulation.
// Define CIM_ACC_RELU_EN to clamp negative final output lanes to zero.
module cim_conv_array_acc #(
  parameter int K        = 3,
  parameter int MAX_W    = 32,
  parameter int MAX_PASS = 16,
  parameter int MAC_W    = cim_pkg::MAC_W,
  parameter int TREE_W   = cim_pkg::tree_w(MAC_W, K),
  parameter int ACC_W    = cim_pkg::acc_w(TREE_W, MAX_PASS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  CIM_en,
  input  logic                                  STDW,
  input  logic                                  STDR,
  input  logic [5:0]                            STD_A,
  input  logic [K*K*cim_pkg::WGT_ROW_W-1:0]     weight_in,
  output logic [K*K*cim_pkg::WGT_ROW_W-1:0]     weight_out,
  input  logic [K*cim_pkg::ACT_VEC_W-1:0]       act_in,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [$clog2(MAX_W+1)-1:0]            cfg_width,
  input  logic [$clog2(MAX_PASS+1)-1:0]         cfg_passes,
  input  logic                                  start,
  output logic [cim_pkg::MACRO_COLS*ACC_W-1:0]  out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  pass_done
);

  import cim_pkg::*;

  localparam int LANES = MACRO_COLS;
  localparam int NM    = K * K;
  localparam int XW    = $clog2(MAX_W + 1);
  localparam int PW    = $clog2(MAX_PASS + 1);
  localparam int AW    = $clog2(MAX_W);
  localparam int RW    = K * ACT_VEC_W;

  state_t                    state;
  logic [XW-1:0]             x, width_r;
  logic [PW-1:0]             pass, passes_r;
  logic [RW-1:0]             sh [1:K-1];
  logic [RW-1:0]             col_act [K];
  logic [LANES*MAC_W-1:0]    psum [NM];
  logic signed [TREE_W-1:0]  tree_sum [LANES];
  logic [LANES*ACC_W-1:0]    addend, acc_sum, final_data;
  logic [AW-1:0]             o_idx;
  logic macro_en, accept, produce, last_beat, last_pass, cfg_ok;

  // Column 0 sees the incoming beat directly; older beats sit in the shift registers.
  always_comb begin
    col_act[0] = act_in;
    for (int c = 1; c < K; c++) col_act[c] = sh[c];
  end

  assign macro_en = CIM_en && (state == STREAM);

  for (genvar gr = 0; gr < K; gr++) begin : g_row
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      Macro u_macro (
        .clk        (clk),
        .CIM_en     (macro_en),
        .STDW       (STDW),
        .STDR       (STDR),
        .STD_A      (STD_A),
        .weight_in  (weight_in[(gr*K+gc)*WGT_ROW_W +: WGT_ROW_W]),
        .weight_out (weight_out[(gr*K+gc)*WGT_ROW_W +: WGT_ROW_W]),
        .act_in     (col_act[gc][gr*ACT_VEC_W +: ACT_VEC_W]),
        .psum       (psum[gr*K+gc])
      );
    end
  end

  always_comb begin
    addend = '0;
    for (int l = 0; l < LANES; l++) begin
      tree_sum[l] = '0;
      for (int m = 0; m < NM; m++) begin
        tree_sum[l] = tree_sum[l] + TREE_W'($signed(psum[m][l*MAC_W +: MAC_W]));
      end
      addend[l*ACC_W +: ACC_W] = ACC_W'(tree_sum[l]);
    end
  end

  assign in_ready  = (state == STREAM) && !STDW && !STDR && !(out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign produce   = accept && (x >= XW'(K - 1));
  assign last_beat = (x == width_r - 1'b1);
  assign last_pass = (pass == passes_r - 1'b1);
  assign o_idx     = AW'(x - XW'(K - 1));
  assign cfg_ok    = (cfg_width >= XW'(2)) && (cfg_width <= XW'(MAX_W)) && (cfg_width >= XW'(K))
                  && (cfg_passes >= PW'(1)) && (cfg_passes <= PW'(MAX_PASS));

  cim_acc_linebuf #(
    .DEPTH (MAX_W),
    .LANES (LANES),
    .ACC_W (ACC_W),
    .AW    (AW)
  ) u_linebuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (produce),
    .first  (pass == '0),
    .addr   (o_idx),
    .addend (addend),
    .sum    (acc_sum)
  );

  always_comb begin
    final_data = acc_sum;
`ifdef CIM_ACC_RELU_EN
    for (int l = 0; l < LANES; l++) begin
      if (acc_sum[l*ACC_W + ACC_W - 1]) final_data[l*ACC_W +: ACC_W] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      width_r   <= '0;
      pass      <= '0;
      passes_r  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      for (int c = 1; c < K; c++) sh[c] <= '0;
    end else begin
      pass_done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        for (int c = K - 1; c >= 2; c--) sh[c] <= sh[c-1];
        sh[1] <= act_in;
        x     <= x + 1'b1;
      end
      // A fresh result overrides the clear above, so the register reloads on the same edge.
      if (produce && last_pass) begin
        out_data  <= final_data;
        out_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            state    <= STREAM;
            busy     <= 1'b1;
            width_r  <= cfg_width;
            passes_r <= cfg_passes;
            pass     <= '0;
            x        <= '0;
            for (int c = 1; c < K; c++) sh[c] <= '0;
          end
        end
        STREAM: begin
          if (accept && last_beat) begin
            if (last_pass) begin
              state <= DRAIN;
            end else begin
              pass_done <= 1'b1;
              pass      <= pass + 1'b1;
              state     <= WAIT_PASS;
              x         <= '0;
              for (int c = 1; c < K; c++) sh[c] <= '0;
            end
          end
        end
        WAIT_PASS: begin
          if (start) state <= STREAM;
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_conv_array_acc.sv
// Directed bench for cim_conv_array_acc with K=3: single/multi-pass sums, stalls, weight access, reset abort.
module tb_cim_conv_array_acc;

  localparam int K     = 3;
  localparam int ACC_W = 22;
  localparam int OW    = 8 * ACC_W;

  logic                 clk = 1'b0;
  logic                 rst_n, CIM_en, STDW, STDR, start, in_valid, out_ready;
  logic [5:0]           STD_A;
  logic [K*K*32-1:0]    weight_in, weight_out;
  logic [K*256-1:0]     act_in;
  logic [5:0]           cfg_width;
  logic [4:0]           cfg_passes;
  logic [OW-1:0]        out_data;
  logic                 out_valid, in_ready, busy, pass_done;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_cycles = 0;
  int pd_cnt = 0;
  logic [OW-1:0] got [$];

  always #5 clk = ~clk;

  cim_conv_array_acc #(.K(K)) dut (
    .clk(clk), .rst_n(rst_n), .CIM_en(CIM_en), .STDW(STDW), .STDR(STDR), .STD_A(STD_A),
    .weight_in(weight_in), .weight_out(weight_out), .act_in(act_in), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_width(cfg_width), .cfg_passes(cfg_passes), .start(start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .pass_done(pass_done)
  );

  always @(negedge clk) begin
    if (out_valid) vld_cycles++;
    if (out_valid && out_ready) got.push_back(out_data);
    if (pass_done) pd_cnt++;
  end

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] rep(input int v);
    logic [OW-1:0] r;
    for (int l = 0; l < 8; l++) r[l*ACC_W +: ACC_W] = ACC_W'(v);
    return r;
  endfunction

  function automatic logic [K*256-1:0] act_all(input logic [3:0] v);
    return {(K*64){v}};
  endfunction

  task automatic load_weights(input logic [31:0] v);
    STDW = 1'b1;
    weight_in = {(K*K){v}};
    for (int r = 0; r < 64; r++) begin
      STD_A = 6'(r);
      @(posedge clk); #1;
    end
    STDW = 1'b0;
  endtask

  task automatic start_job(input int w, input int p);
    cfg_width = 6'(w);
    cfg_passes = 5'(p);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [K*256-1:0] a);
    int t;
    in_valid = 1'b1;
    act_in = a;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("beat_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input string tag, input int base, input int n, input int v0, input int step);
    check({tag, "_n"}, got.size() - base, n);
    for (int i = 0; i < n && base + i < got.size(); i++)
      check(tag, got[base+i], rep(v0 + i * step));
  endtask

  task automatic pass_ones(input int w);
    for (int b = 0; b < w; b++) send_beat(act_all(4'h1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, vbase, pbase;
    rst_n = 1'b0; CIM_en = 1'b1; STDW = 1'b0; STDR = 1'b0; STD_A = '0; start = 1'b0;
    weight_in = '0; act_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_width = '0; cfg_passes = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pass_done", pass_done, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_weights(32'h1111_1111);

    // W < K is illegal and must leave the block idle.
    start_job(2, 1);
    @(negedge clk);
    check("illegal_cfg_busy", busy, 0);
    @(posedge clk); #1;

    // Single pass, all ones: 9 macros x 64 = 576 per lane.
    base = got.size(); vbase = vld_cycles;
    start_job(5, 1);
    @(negedge clk);
    check("s1_busy", busy, 1);
    check("s1_in_ready", in_ready, 1);
    @(posedge clk); #1;
    pass_ones(5);
    wait_idle("s1_idle");
    check_outs("s1_out", base, 3, 576, 0);
    check("s1_vld_cycles", vld_cycles - vbase, 3);

    // Two passes; second start carries a different width that must be ignored.
    base = got.size(); pbase = pd_cnt;
    start_job(5, 2);
    pass_ones(5);
    @(negedge clk);
    check("s2_pass_done", pass_done, 1);
    check("s2_wait_in_ready", in_ready, 0);
    check("s2_no_out_pass0", got.size() - base, 0);
    @(posedge clk); #1;
    start_job(3, 7);
    pass_ones(5);
    wait_idle("s2_idle");
    check_outs("s2_out", base, 3, 1152, 0);
    check("s2_pd_cnt", pd_cnt - pbase, 1);

    // Rewrite row 5 to weight 2 between passes: pass1 = 9 x (63 + 2) = 585, total 1161.
    base = got.size();
    start_job(5, 2);
    pass_ones(5);
    STDW = 1'b1; STD_A = 6'd5; weight_in = {(K*K){32'h2222_2222}};
    @(posedge clk); #1;
    STDW = 1'b0; STDR = 1'b1;
    @(negedge clk);
    check("s3_readback", weight_out, {(K*K){32'h2222_2222}});
    check("s3_stdr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    STDR = 1'b0;
    start_job(5, 2);
    pass_ones(5);
    wait_idle("s3_idle");
    check_outs("s3_out", base, 3, 1161, 0);
    STDW = 1'b1; weight_in = {(K*K){32'h1111_1111}};
    @(posedge clk); #1;
    STDW = 1'b0;

    // Weights -1: raw sum is -576 per lane, clamped to 0 when ReLU is built in.
    load_weights(32'hFFFF_FFFF);
    base = got.size();
    start_job(5, 1);
    pass_ones(5);
    wait_idle("s4_idle");
`ifdef CIM_ACC_RELU_EN
    check_outs("s4_out", base, 3, 0, 0);
`else
    check_outs("s4_out", base, 3, -576, 0);
`endif
    load_weights(32'h1111_1111);

    // Ramp acts x+1, W=7: out[o] = 192*(3o+6) = 1152 + 576*o; stall downstream for 4 cycles.
    base = got.size();
    start_job(7, 1);
    fork
      begin
        for (int b = 0; b < 7; b++) send_beat(act_all(4'(b + 1)));
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("s5_stall_in_ready", in_ready, 0);
          check("s5_stall_data", out_data, rep(1728));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle("s5_idle");
    check_outs("s5_seq", base, 5, 1152, 576);

    // Reset during pass 1 after beat 2, then a fresh single-pass job.
    start_job(5, 2);
    pass_ones(5);
    start_job(5, 2);
    pass_ones(3);
    rst_n = 1'b0;
    #1;
    check("s6_rst_out_valid", out_valid, 0);
    check("s6_rst_out_data", out_data, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = got.size();
    start_job(5, 1);
    pass_ones(5);
    wait_idle("s6_idle");
    check_outs("s6_out", base, 3, 576, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
